// File: rtl/fpu_to_int_if.sv
// fpu_to_int_if: operand/result handshake bundle between the adder side and the float-to-int converter.
interface fpu_to_int_if;
  logic [31:0] op_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic        out_valid;
  logic        out_ready;
  modport master (output op_in, in_valid, out_ready, input in_ready, data_out, status_out, out_valid);
  modport slave  (input op_in, in_valid, out_ready, output in_ready, data_out, status_out, out_valid);
endinterface

// File: rtl/fpu_to_int.sv
// fpu_to_int: sequential FPU-format to int32 converter, bit-serial alignment, round to nearest even.
// Define F2I_SATURATE_EN to clamp overflow results to the int32 limits instead of returning zero.
module fpu_to_int (
  input logic        clock100KHz,
  input logic        reset,
  fpu_to_int_if.slave io
);
  typedef enum logic [2:0] {IDLE, CHECK, SHIFT, ROUND, DONE} state_t;
  localparam logic [3:0] ST_EXACT = 4'b0001, ST_INEXACT = 4'b0010, ST_OVF = 4'b0100, ST_UNF = 4'b1000;
  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d, data_q, data_d;
  logic [3:0]  status_q, status_d;
  logic [5:0]  exp_q, exp_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d, left_q, left_d, g_q, g_d, stk_q, stk_d;
  logic        frac_nz, ovf, up;
  logic [4:0]  k_right, k_left;
  logic [31:0] sum, sat_val;
  assign frac_nz = |mag_q[24:0];
  // -2^31 is the only e==62 value that still fits
  assign ovf     = exp_q == 6'd63 || (exp_q == 6'd62 && !(sign_q && !frac_nz));
  assign k_right = 5'(6'd56 - exp_q);
  assign k_left  = 5'(exp_q - 6'd56);
  assign up      = g_q & (stk_q | mag_q[0]);
  assign sum     = mag_q + {31'd0, up};
`ifdef F2I_SATURATE_EN
  assign sat_val = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
  assign sat_val = 32'h0000_0000;
`endif
  assign io.in_ready   = reset && state_q == IDLE;
  assign io.out_valid  = state_q == DONE;
  assign io.data_out   = data_q;
  assign io.status_out = status_q;
  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    data_d   = data_q;
    status_d = status_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    left_d   = left_q;
    g_d      = g_q;
    stk_d    = stk_q;
    case (state_q)
      IDLE: if (io.in_valid) begin
        sign_d  = io.op_in[31];
        exp_d   = io.op_in[30:25];
        mag_d   = {6'd0, 1'b1, io.op_in[24:0]};
        g_d     = 1'b0;
        stk_d   = 1'b0;
        state_d = CHECK;
      end
      CHECK: if (exp_q == 6'd0) begin
        data_d   = 32'd0;
        status_d = frac_nz ? ST_UNF : ST_EXACT;
        state_d  = DONE;
      end else if (ovf) begin
        data_d   = sat_val;
        status_d = ST_OVF;
        state_d  = DONE;
      end else if (exp_q <= 6'd29) begin
        data_d   = 32'd0;
        status_d = ST_INEXACT;
        state_d  = DONE;
      end else if (exp_q <= 6'd55) begin
        left_d  = 1'b0;
        cnt_d   = k_right;
        state_d = SHIFT;
      end else begin
        left_d  = 1'b1;
        cnt_d   = k_left;
        state_d = k_left == 5'd0 ? ROUND : SHIFT;
      end
      SHIFT: begin
        mag_d   = left_q ? {mag_q[30:0], 1'b0} : {1'b0, mag_q[31:1]};
        g_d     = left_q ? g_q : mag_q[0];
        stk_d   = left_q ? stk_q : stk_q | g_q;
        cnt_d   = cnt_q - 5'd1;
        state_d = cnt_q == 5'd1 ? ROUND : SHIFT;
      end
      ROUND: begin
        data_d   = sign_q ? -sum : sum;
        status_d = (g_q | stk_q) ? ST_INEXACT : ST_EXACT;
        state_d  = DONE;
      end
      DONE:    state_d = io.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock100KHz) begin
    if (!reset) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      data_q   <= '0;
      status_q <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      left_q   <= 1'b0;
      g_q      <= 1'b0;
      stk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      data_q   <= data_d;
      status_q <= status_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      left_q   <= left_d;
      g_q      <= g_d;
      stk_q    <= stk_d;
    end
  end
endmodule

// File: tb/tb_fpu_to_int.sv
// tb_fpu_to_int: directed vectors against an arithmetic reference model of fpu_to_int.
module tb_fpu_to_int;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fpu_to_int_if bus ();
  fpu_to_int dut (.clock100KHz(clk), .reset(rst_n), .io(bus));
  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] exp_d = '0;
  logic [3:0]  exp_s = '0;
`ifdef F2I_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask
  // value = {1,f} * 2^(e-56); integer division with remainder gives the round-to-even result
  function automatic void model(input logic [31:0] op, output logic [31:0] d, output logic [3:0] st, output int lat);
    logic s;
    int e, sh;
    longint m, q, rem, half, v;
    s = op[31];
    e = int'(op[30:25]);
    m = longint'({1'b1, op[24:0]});
    if (e == 0) begin
      d = 32'd0; st = (op[24:0] != 0) ? 4'b1000 : 4'b0001; lat = 2;
    end else if (e <= 55) begin
      sh   = 56 - e;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      d   = s ? 32'(-q) : 32'(q);
      st  = (rem != 0) ? 4'b0010 : 4'b0001;
      lat = (e >= 30) ? sh + 3 : 2;
    end else begin
      v = m << (e - 56);
      if (v > 64'sd2147483647 && !(s && v == 64'sd2147483648)) begin
        d = SAT ? (s ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'h0; st = 4'b0100; lat = 2;
      end else begin
        d = s ? 32'(-v) : 32'(v); st = 4'b0001; lat = e - 56 + 3;
      end
    end
  endfunction
  task automatic pin(input logic [31:0] op, input logic [31:0] d_req, input logic [3:0] s_req, input int lat_req);
    logic [31:0] d;
    logic [3:0] s;
    int lat;
    model(op, d, s, lat);
    chk($sformatf("model_data %h", op), d, d_req);
    chk($sformatf("model_status %h", op), 32'(s), 32'(s_req));
    chk($sformatf("model_latency %h", op), lat, lat_req);
  endtask
  // issue one operand; returns at the negedge before the edge where out_valid is first sampled high
  task automatic run(input logic [31:0] op, input logic rdy);
    logic [31:0] d;
    logic [3:0] s;
    int lat, n;
    model(op, d, s, lat);
    @(negedge clk);
    bus.op_in = op; bus.in_valid = 1'b1; bus.out_ready = rdy;
    n = 0;
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(n < 100), 32'd1);
    @(posedge clk);
    exp_d = d; exp_s = s;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
    chk($sformatf("latency %h", op), n, lat);
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      chk("data_out", bus.data_out, exp_d);
      chk("status_out", 32'(bus.status_out), 32'(exp_s));
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.op_in = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    pin(32'h3E00_0000, 32'h0000_0001, 4'b0001, 28);
    pin(32'h4080_0000, 32'h0000_0002, 4'b0010, 27);
    pin(32'h4180_0000, 32'h0000_0004, 4'b0010, 27);
    pin(32'hC280_0000, 32'hFFFF_FFFB, 4'b0001, 26);
    pin(32'hFC00_0000, 32'h8000_0000, 4'b0001, 9);
    pin(32'h7C00_0000, SAT ? 32'h7FFF_FFFF : 32'h0, 4'b0100, 2);
    pin(32'h0000_0001, 32'h0000_0000, 4'b1000, 2);
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", bus.data_out, 32'd0);
    chk("rst_status", 32'(bus.status_out), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    foreach (vec[i]) run(vec[i], 1'b1);
    run(32'hC280_0000, 1'b0);
    bus.op_in = 32'h3E00_0000; bus.in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_released", 32'(bus.out_valid), 32'd0);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd1);
    run(32'h4080_0000, 1'b1);
    @(negedge clk);
    bus.op_in = 32'h3E00_0000; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data", bus.data_out, 32'd0);
    chk("mid_rst_status", 32'(bus.status_out), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    run(32'h3E00_0000, 1'b1);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
  logic [31:0] vec [15] = '{
    32'h3E00_0000, 32'h4080_0000, 32'h4180_0000, 32'hC280_0000, 32'hFC00_0000,
    32'h7C00_0000, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 32'h7E00_0000,
    32'hFE00_0000, 32'h3A00_0000, 32'h3C00_0000, 32'h7000_0000, 32'h7BFF_FFFF
  };
endmodule
